smart_home_ctrl_p: RTL and testbench
====================================

// Module: smart_home_ctrl_p
// PURPOSE
//  Parametrised next-generation smart-home controller. It debounces the door, window and fire sensors and
//  prioritises them into a single registered state. The state drives one-hot actuator/buzzer outputs and a
//  3-bit display code.
//  Adds configurable temperature thresholds with hysteresis, a minimum alarm hold time and a saturating
//  alarm-event counter. Sits between the raw sensor inputs and the actuator/display drivers; one instance per home.
// PARAMETERS
//  TEMP_W      7   width of temperature input ST (unsigned)
//  HEAT_TH     50  heat request when ST < HEAT_TH
//  COOL_TH     70  cool request when ST > COOL_TH
//  HYST        2   hysteresis band; requires HEAT_TH+HYST <= COOL_TH-HYST
//  DEB_CYC     4   consecutive stable cycles before a filtered sensor changes (>=1)
//  ALARM_HOLD  8   cycles ALARM persists after filtered SFA falls (>=0)
//  CNT_W       8   width of alarm_cnt
// PORTS
//  clk        in   1        single clock, all state on rising edge
//  Rst        in   1        synchronous reset, active-high
//  SFD        in   1        front-door sensor (raw, synchronous to clk)
//  SRD        in   1        rear-door sensor (raw)
//  SW         in   1        window sensor (raw)
//  SFA        in   1        fire-alarm sensor (raw)
//  ST         in   TEMP_W   temperature, unsigned, not filtered
//  fdoor      out  1        front door actuator (state FDOOR)
//  rdoor      out  1        rear door actuator (state RDOOR)
//  winbuzz    out  1        window buzzer (state WINDOW)
//  alarmbuzz  out  1        fire alarm buzzer (state ALARM)
//  heater     out  1        heater on (state HEATER)
//  cooler     out  1        cooler on (state COOLER)
//  display    out  3        state code: IDLE 000, FDOOR 001, RDOOR 010, ALARM 011, WINDOW 100, HEATER 101, COOLER 110
//  alarm_cnt  out  CNT_W    number of entries into ALARM, saturating
// BEHAVIOUR
//  Reset (Rst=1 at an edge): state=IDLE, display=000, all actuator outputs 0, filtered sensors 0,
//   debounce counters 0, hold timer 0, alarm_cnt 0. Rst mid-operation overrides everything in the same edge.
//  Debounce, per sensor: if raw==filt then cnt<=0. Else if cnt==DEB_CYC-1 then filt<=raw and cnt<=0.
//   Otherwise cnt<=cnt+1. A glitch shorter than DEB_CYC cycles never changes filt.
//  Hold timer: if sfa_f then tmr<=ALARM_HOLD; else if state==ALARM && tmr!=0 then tmr<=tmr-1.
//   alarm_req = sfa_f | (state==ALARM && tmr!=0).
//  Heat request: ST < HEAT_TH + HYST when state==HEATER, else ST < HEAT_TH.
//  Cool request: ST > COOL_TH - HYST when state==COOLER, else ST > COOL_TH.
//  Next state, every cycle, fixed priority: alarm_req > sfd_f > srd_f > sw_f > heat_req > cool_req > IDLE.
//   Any state may move to any other state in one cycle. A preempted HEATER/COOLER re-evaluates using the
//   entry (non-hysteresis) threshold.
//  Outputs are a combinational decode of the state register, exactly one high or all low in IDLE.
//  Latency: raw sensor edge -> output change = DEB_CYC+1 cycles; ST change -> output change = 1 cycle.
//  alarm_cnt increments on each transition into ALARM from a non-ALARM state. It holds at 2^CNT_W-1 and
//   is cleared only by Rst.
//  Simultaneous filtered events resolve by priority only; lower requests are not queued.
// TESTING
//  T1 reset: Rst=1 two cycles with all inputs active -> display=000, all outputs 0, alarm_cnt=0.
//  T2 debounce: SFD pulses of 3 cycles (DEB_CYC=4) -> no change. SFD held 4 cycles -> fdoor=1 and
//     display=001 on cycle 5.
//  T3 priority: SFD,SRD,SW active, then SFA raised -> display 001 then 011. Drop SFA -> ALARM held 8 more
//     cycles, then display=001. alarm_cnt=1.
//  T4 hysteresis: ST 51->49 -> heater=1; ST=51 -> still heater; ST=52 -> display=000.
//     ST=71 -> cooler=1; ST=69 -> still cooler; ST=68 -> display=000.
//  T5 saturation: CNT_W=2, four SFA episodes -> alarm_cnt 1,2,3,3.
//  T6 reset mid-ALARM with tmr!=0 -> next cycle display=000, alarm_cnt=0, tmr=0.

Source files
------------

// File: rtl/smart_home_ctrl_p.sv
// Smart-home controller: debounced door/window/fire sensors and hysteretic temperature
// requests are prioritised into one registered state that drives one-hot actuators and a display code.
module smart_home_ctrl_p #(
  parameter int TEMP_W     = 7,
  parameter int HEAT_TH    = 50,
  parameter int COOL_TH    = 70,
  parameter int HYST       = 2,
  parameter int DEB_CYC    = 4,
  parameter int ALARM_HOLD = 8,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              SFD,
  input  logic              SRD,
  input  logic              SW,
  input  logic              SFA,
  input  logic [TEMP_W-1:0] ST,
  output logic              fdoor,
  output logic              rdoor,
  output logic              winbuzz,
  output logic              alarmbuzz,
  output logic              heater,
  output logic              cooler,
  output logic [2:0]        display,
  output logic [CNT_W-1:0]  alarm_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FDOOR  = 3'd1,
    RDOOR  = 3'd2,
    ALARM  = 3'd3,
    WINDOW = 3'd4,
    HEATER = 3'd5,
    COOLER = 3'd6
  } state_t;

  localparam int DW = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC);
  localparam int TW = (ALARM_HOLD < 1) ? 1 : $clog2(ALARM_HOLD + 1);
  localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [TW-1:0]    HOLD_V   = TW'(ALARM_HOLD);
  localparam logic [TEMP_W:0]  HEAT_LO  = (TEMP_W + 1)'(HEAT_TH);
  localparam logic [TEMP_W:0]  HEAT_HI  = (TEMP_W + 1)'(HEAT_TH + HYST);
  localparam logic [TEMP_W:0]  COOL_HI  = (TEMP_W + 1)'(COOL_TH);
  localparam logic [TEMP_W:0]  COOL_LO  = (TEMP_W + 1)'(COOL_TH - HYST);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Sensor bit order: 0 front door, 1 rear door, 2 window, 3 fire.
  logic [3:0]          raw;
  logic [3:0]          filt_q, filt_d;
  logic [DW-1:0]       cnt_q [4];
  logic [DW-1:0]       cnt_d [4];
  logic [TW-1:0]       tmr_q, tmr_d;
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    acnt_q, acnt_d;
  logic [TEMP_W:0]     st_x;
  logic                alarm_req, heat_req, cool_req;

  assign raw  = {SFA, SW, SRD, SFD};
  assign st_x = {1'b0, ST};

  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (raw[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_LAST) begin
        filt_d[i] = raw[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // The hold timer keeps ALARM alive after the filtered fire sensor falls.
  always_comb begin
    tmr_d = tmr_q;
    if (filt_q[3]) begin
      tmr_d = HOLD_V;
    end else if (state_q == ALARM && tmr_q != '0) begin
      tmr_d = tmr_q - 1'b1;
    end
  end

  assign alarm_req = filt_q[3] | (state_q == ALARM && tmr_q != '0);
  assign heat_req  = (state_q == HEATER) ? (st_x < HEAT_HI) : (st_x < HEAT_LO);
  assign cool_req  = (state_q == COOLER) ? (st_x > COOL_LO) : (st_x > COOL_HI);

  always_comb begin
    state_d = IDLE;
    if (alarm_req)      state_d = ALARM;
    else if (filt_q[0]) state_d = FDOOR;
    else if (filt_q[1]) state_d = RDOOR;
    else if (filt_q[2]) state_d = WINDOW;
    else if (heat_req)  state_d = HEATER;
    else if (cool_req)  state_d = COOLER;
  end

  always_comb begin
    acnt_d = acnt_q;
    if (state_d == ALARM && state_q != ALARM && acnt_q != CNT_MAX) begin
      acnt_d = acnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      filt_q  <= '0;
      tmr_q   <= '0;
      state_q <= IDLE;
      acnt_q  <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      filt_q  <= filt_d;
      tmr_q   <= tmr_d;
      state_q <= state_d;
      acnt_q  <= acnt_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign fdoor     = (state_q == FDOOR);
  assign rdoor     = (state_q == RDOOR);
  assign winbuzz   = (state_q == WINDOW);
  assign alarmbuzz = (state_q == ALARM);
  assign heater    = (state_q == HEATER);
  assign cooler    = (state_q == COOLER);
  assign display   = state_q;
  assign alarm_cnt = acnt_q;

endmodule

// File: tb/tb_smart_home_ctrl_p.sv
// Directed bench for smart_home_ctrl_p; a second instance with CNT_W=2 covers counter saturation.
module tb_smart_home_ctrl_p;

  logic       clk = 1'b0;
  logic       Rst = 1'b1;
  logic       SFD = 1'b0, SRD = 1'b0, SW = 1'b0, SFA = 1'b0;
  logic [6:0] ST = 7'd60;

  logic       fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler;
  logic [2:0] display;
  logic [7:0] alarm_cnt;
  logic       fdoor2, rdoor2, winbuzz2, alarmbuzz2, heater2, cooler2;
  logic [2:0] display2;
  logic [1:0] alarm_cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  smart_home_ctrl_p dut (
    .clk(clk), .Rst(Rst), .SFD(SFD), .SRD(SRD), .SW(SW), .SFA(SFA), .ST(ST),
    .fdoor(fdoor), .rdoor(rdoor), .winbuzz(winbuzz), .alarmbuzz(alarmbuzz),
    .heater(heater), .cooler(cooler), .display(display), .alarm_cnt(alarm_cnt)
  );

  smart_home_ctrl_p #(.CNT_W(2)) dut2 (
    .clk(clk), .Rst(Rst), .SFD(SFD), .SRD(SRD), .SW(SW), .SFA(SFA), .ST(ST),
    .fdoor(fdoor2), .rdoor(rdoor2), .winbuzz(winbuzz2), .alarmbuzz(alarmbuzz2),
    .heater(heater2), .cooler(cooler2), .display(display2), .alarm_cnt(alarm_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // T1: reset with every input active
    Rst = 1'b1; SFD = 1'b1; SRD = 1'b1; SW = 1'b1; SFA = 1'b1; ST = 7'd10;
    step(2);
    chk("t1_display", display, 0);
    chk("t1_outs", {fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler}, 0);
    chk("t1_cnt", alarm_cnt, 0);
    SFD = 0; SRD = 0; SW = 0; SFA = 0; ST = 7'd60;
    Rst = 1'b0;
    step(2);
    chk("t1_idle", display, 0);

    // T2: 3-cycle glitches never pass the filter
    for (int k = 0; k < 2; k++) begin
      SFD = 1'b1; step(3);
      SFD = 1'b0; step(3);
      chk("t2_glitch", display, 0);
    end
    SFD = 1'b1;
    step(4);
    chk("t2_not_yet", display, 0);
    step(1);
    chk("t2_display", display, 1);
    chk("t2_fdoor", fdoor, 1);

    // T3: priority and alarm hold
    SRD = 1'b1; SW = 1'b1;
    step(6);
    chk("t3_fdoor_wins", display, 1);
    SFA = 1'b1;
    step(4);
    chk("t3_pre_alarm", display, 1);
    step(1);
    chk("t3_alarm", display, 3);
    chk("t3_buzz", alarmbuzz, 1);
    chk("t3_cnt", alarm_cnt, 1);
    SFA = 1'b0;
    step(12);
    chk("t3_hold", display, 3);
    step(1);
    chk("t3_release", display, 1);
    chk("t3_cnt_after", alarm_cnt, 1);
    SFD = 1'b0; step(5);
    chk("t3_rdoor", display, 2);
    chk("t3_rdoor_out", rdoor, 1);
    SRD = 1'b0; step(5);
    chk("t3_window", display, 4);
    chk("t3_winbuzz", winbuzz, 1);
    SW = 1'b0; step(5);
    chk("t3_idle", display, 0);

    // T4: temperature hysteresis
    ST = 7'd51; step(1); chk("t4_51", display, 0);
    ST = 7'd49; step(1); chk("t4_49", heater, 1);
    ST = 7'd51; step(1); chk("t4_51_hold", display, 5);
    ST = 7'd52; step(1); chk("t4_52", display, 0);
    ST = 7'd71; step(1); chk("t4_71", cooler, 1);
    ST = 7'd69; step(1); chk("t4_69_hold", display, 6);
    ST = 7'd68; step(1); chk("t4_68", display, 0);
    ST = 7'd60;

    // T5: saturating counter on the narrow instance
    Rst = 1'b1; step(1); Rst = 1'b0;
    chk("t5_cnt0", alarm_cnt2, 0);
    for (int e = 1; e <= 4; e++) begin
      SFA = 1'b1; step(5);
      chk("t5_alarm", display2, 3);
      SFA = 1'b0; step(13);
      chk("t5_idle", display2, 0);
      chk("t5_cnt", alarm_cnt2, (e > 3) ? 3 : e);
    end
    chk("t5_wide_cnt", alarm_cnt, 4);

    // T6: reset in the middle of the hold window
    SFA = 1'b1; step(5);
    SFA = 1'b0; step(6);
    chk("t6_in_alarm", display, 3);
    Rst = 1'b1; step(1);
    chk("t6_display", display, 0);
    chk("t6_cnt", alarm_cnt, 0);
    chk("t6_tmr", dut.tmr_q, 0);
    Rst = 1'b0; step(2);
    chk("t6_stays_idle", display, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
